// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu #(
  parameter int width = 32
) (
  input  logic [2:0]       op_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] out_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             negative_o
);
  logic             sub;
  logic [width-1:0] b_eff;
  logic [width-1:0] sum;

  // Flags always come from the add/sub path, even for logic opcodes.
  always_comb begin
    sub        = op_i[0];
    b_eff      = sub ? ~b_i : b_i;
    sum        = a_i + b_eff + {{(width-1){1'b0}}, sub};
    overflow_o = (a_i[width-1] == b_eff[width-1]) && (sum[width-1] != a_i[width-1]);
    zero_o     = (sum == '0);
    negative_o = sum[width-1];
    unique case (op_i)
      3'b100:  out_o = a_i & b_i;
      3'b101:  out_o = a_i | b_i;
      3'b110:  out_o = ~(a_i | b_i);
      3'b111:  out_o = a_i ^ b_i;
      default: out_o = sum;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int width = 32
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [width-1:0] req0_a_i,
  input  logic [width-1:0] req0_b_i,
  input  logic [2:0]       req0_op_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [width-1:0] req1_a_i,
  input  logic [width-1:0] req1_b_i,
  input  logic [2:0]       req1_op_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [width-1:0] rsp_out_o,
  output logic             rsp_overflow_o,
  output logic             rsp_zero_o,
  output logic             rsp_negative_o
);
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             id_q, id_d;
  logic [width-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic             slot_free, grant_valid, grant, accept;
  logic [2:0]       alu_op;
  logic [width-1:0] alu_a, alu_b, alu_out;
  logic             alu_ovf, alu_zero, alu_neg;

  // With no grant the mux falls back to requester 0; nothing is captured then.
  always_comb begin
    slot_free    = !valid_q || rsp_ready_i;
    grant_valid  = req0_valid_i || req1_valid_i;
    grant        = (req0_valid_i && req1_valid_i) ? !last_q : req1_valid_i;
    accept       = grant_valid && slot_free;
    req0_ready_o = accept && !grant;
    req1_ready_o = accept && grant;
    alu_op       = grant ? req1_op_i : req0_op_i;
    alu_a        = grant ? req1_a_i  : req0_a_i;
    alu_b        = grant ? req1_b_i  : req0_b_i;
  end

  alu #(.width(width)) u_alu (
    .op_i       (alu_op),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .out_o      (alu_out),
    .overflow_o (alu_ovf),
    .zero_o     (alu_zero),
    .negative_o (alu_neg)
  );

  always_comb begin
    last_d  = last_q;
    valid_d = valid_q;
    id_d    = id_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (accept) begin
      last_d  = grant;
      valid_d = 1'b1;
      id_d    = grant;
      out_d   = alu_out;
      ovf_d   = alu_ovf;
      zero_d  = alu_zero;
      neg_d   = alu_neg;
    end else if (valid_q && rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign rsp_valid_o    = valid_q;
  assign rsp_id_o       = id_q;
  assign rsp_out_o      = out_q;
  assign rsp_overflow_o = ovf_q;
  assign rsp_zero_o     = zero_q;
  assign rsp_negative_o = neg_q;
endmodule
